// File: rtl/riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch
// Purpose  : Instruction fetch stage. Owns the PC and issues in-order word
//            requests on the instruction bus. Returned instructions go into a
//            small in-order queue together with their PC, so fetch or decode
//            stalls never lose bus data. Responses still in flight when a
//            redirect occurs are counted and discarded.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_stallF            - do not start new bus requests
//            i_stallFD           - decode not accepting, hold queue head
//            i_redirect_en/_pc   - taken branch/jump, refetch from target
//            o_ibus_req/_addr    - bus request, held until i_ibus_gnt
//            i_ibus_gnt          - request accepted this cycle
//            i_ibus_rvalid/rdata - in-order response
//            o_instr_valid/o_instr/o_pc - queue head towards decode
// Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stallF,
  input  logic        i_stallFD,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_gnt,
  input  logic        i_ibus_rvalid,
  input  logic [31:0] i_ibus_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  localparam int unsigned          PTR_W   = $clog2(DEPTH);
  localparam int unsigned          CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DEPTH);

  // Request / PC state
  logic [31:0]      pc_q, pc_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // Instruction queue (data + PC per entry)
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [31:0]      pcq_mem_q   [DEPTH];
  logic [31:0]      pcq_mem_d   [DEPTH];

  // PC tag queue: one entry per granted request, popped by every response
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [31:0]      tag_mem_q [DEPTH];
  logic [31:0]      tag_mem_d [DEPTH];

  logic             gnt;
  logic             dropping;
  logic             push;
  logic             pop;
  logic             can_start;
  logic [CNT_W:0]   live_next;

  always_comb begin
    gnt      = req_q & i_ibus_gnt;
    dropping = i_ibus_rvalid & (drop_q != '0);
    // A response arriving in the redirect cycle belongs to the old path.
    push     = i_ibus_rvalid & ~dropping & ~i_redirect_en;
    pop      = (count_q != '0) & ~i_stallFD & ~i_redirect_en;

    outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(i_ibus_rvalid);

    instr_mem_d = instr_mem_q;
    pcq_mem_d   = pcq_mem_q;
    tag_mem_d   = tag_mem_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;

    if (gnt) begin
      tag_mem_d[tag_wr_q] = addr_q;
      tag_wr_d            = tag_wr_q + PTR_W'(1);
    end
    if (i_ibus_rvalid) begin
      tag_rd_d = tag_rd_q + PTR_W'(1);
    end

    if (push) begin
      instr_mem_d[wr_ptr_q] = i_ibus_rdata;
      pcq_mem_d[wr_ptr_q]   = tag_mem_q[tag_rd_q];
    end

    if (i_redirect_en) begin
      // Everything still outstanding after this cycle (including a grant
      // taken right now) belongs to the old path and must be discarded.
      drop_d   = outstanding_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = i_redirect_pc & 32'hFFFF_FFFC;
    end else begin
      drop_d   = drop_q - CNT_W'(dropping);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      pc_d     = gnt  ? pc_q + 32'd4 : pc_q;
    end

    // Credit is judged on post-update values so a request granted this
    // cycle is already accounted for when deciding a back-to-back request.
    // Outstanding is also capped at DEPTH so the tag queue and the counters
    // cannot overflow while old-path responses are still being dropped.
    live_next = {1'b0, count_d} + {1'b0, outstanding_d} - {1'b0, drop_d};
    can_start = (live_next < {1'b0, DEPTH_C}) && (outstanding_d < DEPTH_C)
                && !i_stallF && !i_redirect_en;

    req_d  = req_q;
    addr_d = addr_q;
    if (i_redirect_en) begin
      req_d = 1'b0;
    end else if (req_q && !i_ibus_gnt) begin
      req_d = 1'b1;
    end else if (can_start) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end else begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage needs no reset: every read is qualified by the counters.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pcq_mem_q   <= pcq_mem_d;
    tag_mem_q   <= tag_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == DEPTH_C)));
      assert (!(gnt && (outstanding_q == DEPTH_C)));
    end
  end

  assign o_ibus_req    = req_q;
  assign o_ibus_addr   = addr_q;
  assign o_instr_valid = (count_q != '0);
  assign o_instr       = o_instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign o_pc          = o_instr_valid ? pcq_mem_q[rd_ptr_q]   : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fetch
// Purpose  : Directed self-checking bench for riscv_fetch. A small in-order
//            memory answers granted requests with rdata = addr ^ 32'hA5A5_0000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stallF;
  logic        i_stallFD;
  logic        i_redirect_en;
  logic [31:0] i_redirect_pc;
  logic        o_ibus_req;
  logic [31:0] o_ibus_addr;
  logic        i_ibus_gnt;
  logic        i_ibus_rvalid;
  logic [31:0] i_ibus_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  always #5 clk = ~clk;

  riscv_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stallF      (i_stallF),
    .i_stallFD     (i_stallFD),
    .i_redirect_en (i_redirect_en),
    .i_redirect_pc (i_redirect_pc),
    .o_ibus_req    (o_ibus_req),
    .o_ibus_addr   (o_ibus_addr),
    .i_ibus_gnt    (i_ibus_gnt),
    .i_ibus_rvalid (i_ibus_rvalid),
    .i_ibus_rdata  (i_ibus_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_q[$];
  logic        resp_en;
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  logic [31:0] tgt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshakes seen in the current cycle, advance the edge,
  // then update the memory model and drive the next response.
  task automatic tick();
    logic        g, rv, pp, rd, was_rst, prev_req;
    logic [31:0] prev_addr, rtgt;
    was_rst   = rst;
    g         = !rst && o_ibus_req && i_ibus_gnt;
    rv        = !rst && i_ibus_rvalid;
    rd        = !rst && i_redirect_en;
    pp        = !rst && !rd && o_instr_valid && !i_stallFD;
    prev_req  = o_ibus_req;
    prev_addr = o_ibus_addr;
    rtgt      = i_redirect_pc & 32'hFFFF_FFFC;
    if (g) begin
      check("issue_addr", o_ibus_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (pp) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_instr", o_instr, exp_pc ^ K);
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      exp_addr = rtgt;
      exp_pc   = rtgt;
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      mem_q.delete();
      exp_addr = 32'h0;
      exp_pc   = 32'h0;
    end else begin
      if (rv && mem_q.size() != 0) void'(mem_q.pop_front());
      if (g) begin
        mem_q.push_back(prev_addr);
        check("outstanding_le2", 64'(mem_q.size() <= 2), 64'd1);
      end
      if (prev_req && !g && !rd) begin
        check("req_hold", o_ibus_req, 1);
        check("addr_hold", o_ibus_addr, prev_addr);
      end
    end
    if (resp_en && mem_q.size() != 0) begin
      i_ibus_rvalid = 1'b1;
      i_ibus_rdata  = mem_q[0] ^ K;
    end else begin
      i_ibus_rvalid = 1'b0;
      i_ibus_rdata  = 32'h0;
    end
  endtask

  task automatic run_until(input logic [31:0] pc_tgt, input int bound, input string tag);
    int n = 0;
    while (exp_pc != pc_tgt && n < bound) begin
      tick();
      n++;
    end
    check(tag, exp_pc, pc_tgt);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n = 0;
    while (!o_instr_valid && n < bound) begin
      tick();
      n++;
    end
    check(tag, o_instr_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    i_ibus_gnt = 1'b0;
    i_stallFD  = 1'b0;
    resp_en    = 1'b1;
    while ((mem_q.size() != 0 || o_instr_valid) && n < 20) begin
      tick();
      n++;
    end
    check("drain", {mem_q.size() != 0, o_instr_valid}, 0);
  endtask

  task automatic redirect(input logic [31:0] target);
    i_redirect_en = 1'b1;
    i_redirect_pc = target;
    tick();
    i_redirect_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_stallF = 1'b0; i_stallFD = 1'b0; i_redirect_en = 1'b0;
    i_redirect_pc = 32'h0; i_ibus_gnt = 1'b0; i_ibus_rvalid = 1'b0;
    i_ibus_rdata = 32'h0; resp_en = 1'b0; exp_addr = 32'h0; exp_pc = 32'h0;
    tick();
    tick();

    // Reset state
    check("rst_req",   o_ibus_req,    0);
    check("rst_addr",  o_ibus_addr,   32'h0);
    check("rst_valid", o_instr_valid, 0);
    check("rst_instr", o_instr,       32'h0);
    check("rst_pc",    o_pc,          32'h0);

    // Streaming with gnt tied high, response one cycle after grant
    rst = 1'b0; i_ibus_gnt = 1'b1; resp_en = 1'b1;
    run_until(32'h20, 40, "t1_stream");

    // Decode stall: queue fills, no further requests while credit exhausted
    i_stallFD = 1'b1;
    repeat (6) tick();
    check("t2_req_low",    o_ibus_req,    0);
    check("t2_head_valid", o_instr_valid, 1);
    check("t2_head_pc",    o_pc,          exp_pc);
    check("t2_no_inflight", mem_q.size(), 0);
    tick();
    check("t2_req_still_low", o_ibus_req, 0);
    i_stallFD = 1'b0;
    tgt = exp_pc + 32'h20;
    run_until(tgt, 40, "t2_stream");

    // Two in flight (0x10, 0x14), redirect to 0x103
    drain();
    redirect(32'h10);
    i_ibus_gnt = 1'b1; resp_en = 1'b0;
    repeat (3) tick();
    check("t3_inflight", mem_q.size(), 2);
    check("t3_req_low",  o_ibus_req,   0);
    resp_en = 1'b1;
    redirect(32'h103);
    wait_valid(12, "t3_wait");
    check("t3_first_pc",    o_pc,    32'h100);
    check("t3_first_instr", o_instr, 32'h100 ^ K);
    run_until(32'h110, 30, "t3_stream");

    // Redirect coincident with gnt of 0x20 and rvalid of 0x1C
    drain();
    redirect(32'h18);
    i_ibus_gnt = 1'b1; resp_en = 1'b1;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    resp_en = 1'b1;
    tick();
    check("t4_req",    o_ibus_req,    1);
    check("t4_addr",   o_ibus_addr,   32'h20);
    check("t4_rvalid_setup", i_ibus_rvalid && (i_ibus_rdata == (32'h1C ^ K)), 1);
    redirect(32'h200);
    wait_valid(12, "t4_wait");
    check("t4_first_pc", o_pc, 32'h200);
    run_until(32'h210, 30, "t4_stream");

    // Fetch stall while a request is pending, grant delayed 3 cycles
    drain();
    tick();
    check("t5_pending_req",  o_ibus_req,  1);
    check("t5_pending_addr", o_ibus_addr, exp_addr);
    i_stallF = 1'b1;
    repeat (3) tick();
    check("t5_held_req",  o_ibus_req,  1);
    check("t5_held_addr", o_ibus_addr, exp_addr);
    i_ibus_gnt = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_new_req", o_ibus_req, 0);
    end
    i_stallF = 1'b0;
    tick();
    check("t5_resume_req",  o_ibus_req,  1);
    check("t5_resume_addr", o_ibus_addr, exp_addr);

    // Redirect while fetch-stalled: PC moves, request waits for stall release
    i_stallF = 1'b1;
    redirect(32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5r_no_req", o_ibus_req, 0);
    end
    i_stallF = 1'b0;
    tick();
    check("t5r_req",  o_ibus_req,  1);
    check("t5r_addr", o_ibus_addr, 32'h300);
    run_until(32'h310, 30, "t5r_stream");

    // Reset with a full queue
    i_stallFD = 1'b1;
    repeat (6) tick();
    check("t6_full_valid", o_instr_valid, 1);
    check("t6_full_req",   o_ibus_req,    0);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", o_instr_valid, 0);
    check("t6_rst_req",   o_ibus_req,    0);
    check("t6_rst_addr",  o_ibus_addr,   32'h0);
    rst = 1'b0; i_stallFD = 1'b0;
    run_until(32'h10, 30, "t6_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
